// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with C/V/Z flags.
// The operand is split into STAGES equal slices. Stage k adds slice k using
// the carry registered by stage k-1. Results already computed, together with
// the operand slices not yet added, move forward with the data. A single
// advance signal stalls or shifts every stage at once.
module cla_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int GROUP  = 4
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_carry,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             in_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero
);

  localparam int SW   = WIDTH / STAGES;            // slice width
  localparam int NG   = SW / GROUP;                // lookahead groups per slice
  localparam int NOPS = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int LAST = STAGES - 1;

  // Lookahead adder for one slice. Returns {carry_out, sum}. Group generate
  // and propagate terms set the carry into each group. Inside a group each
  // bit's carry is built from the prefix generate/propagate terms and the
  // group carry-in, not from the previous bit's carry.
  function automatic logic [SW:0] cla_add(input logic [SW-1:0] a,
                                          input logic [SW-1:0] b,
                                          input logic          cin);
    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [SW-1:0] s;
    logic [NG:0]   gc;
    logic          gg;
    logic          gp;
    logic          pg;
    logic          pp;
    g     = a & b;
    p     = a ^ b;
    s     = '0;
    gc    = '0;
    gc[0] = cin;
    for (int n = 0; n < NG; n++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int j = 0; j < GROUP; j++) begin
        gg = g[n*GROUP+j] | (p[n*GROUP+j] & gg);
        gp = gp & p[n*GROUP+j];
      end
      gc[n+1] = gg | (gp & gc[n]);
    end
    for (int n = 0; n < NG; n++) begin
      pg = 1'b0;
      pp = 1'b1;
      for (int j = 0; j < GROUP; j++) begin
        s[n*GROUP+j] = p[n*GROUP+j] ^ (pg | (pp & gc[n]));
        pg = g[n*GROUP+j] | (p[n*GROUP+j] & pg);
        pp = pp & p[n*GROUP+j];
      end
    end
    return {gc[NG], s};
  endfunction

  // Pipeline state
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  sum_q   [STAGES];
  logic              carry_q [STAGES];
  logic [WIDTH-1:0]  x_q     [NOPS];
  logic [WIDTH-1:0]  y_q     [NOPS];
  logic              ovf_q;
  logic              zero_q;

  // Per-stage inputs and next-state values
  logic [WIDTH-1:0]  src_x   [STAGES];
  logic [WIDTH-1:0]  src_y   [STAGES];
  logic              src_c   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic [WIDTH-1:0]  sum_d   [STAGES];
  logic              carry_d [STAGES];
  logic              ovf_d;
  logic              zero_d;

  logic              advance;
  logic [WIDTH-1:0]  y_eff;
  logic              cin_eff;

  // The whole pipe moves when the output slot is empty or being consumed.
  assign advance   = in_ready | ~valid_q[LAST];
  assign out_ready = advance;

  // Subtract is x + ~y + ~borrow.
  assign y_eff   = in_sub ? ~in_y : in_y;
  assign cin_eff = in_sub ? ~in_carry : in_carry;

  assign src_x[0]   = in_x;
  assign src_y[0]   = y_eff;
  assign src_c[0]   = cin_eff;
  assign src_sum[0] = '0;

  // Each stage reads what the previous stage registered.
  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign src_x[k]   = x_q[k-1];
    assign src_y[k]   = y_q[k-1];
    assign src_c[k]   = carry_q[k-1];
    assign src_sum[k] = sum_q[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW:0] r;
    assign r = cla_add(src_x[k][k*SW +: SW], src_y[k][k*SW +: SW], src_c[k]);
    assign carry_d[k] = r[SW];

    // Pass lower result slices through and insert this stage's slice.
    always_comb begin
      // NOTE: assign the whole vector first so no path leaves it unassigned (no latch).
      sum_d[k]              = src_sum[k];
      sum_d[k][k*SW +: SW]  = r[SW-1:0];
    end
  end

  // Flags come from the complete result in the final stage.
  assign ovf_d  = (src_x[LAST][WIDTH-1] == src_y[LAST][WIDTH-1]) &
                  (sum_d[LAST][WIDTH-1] != src_x[LAST][WIDTH-1]);
  assign zero_d = ~|sum_d[LAST];

  // Beat valid bits: cleared by reset, shifted on advance.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      valid_q <= '0;
    end else if (advance) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        valid_q[k] <= valid_q[k-1];
      end
      valid_q[0] <= in_valid;
    end
  end

  // Datapath registers: load on advance, hold otherwise.
  always_ff @(posedge in_clk) begin
    // NOTE: data registers have no reset; the valid bits alone say whether they mean anything.
    if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        x_q[k] <= src_x[k];
        y_q[k] <= src_y[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid    = valid_q[LAST];
  assign out_sum      = sum_q[LAST];
  assign out_carry    = carry_q[LAST];
  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;

endmodule

// File: tb/tb_cla_pipe.sv
// Self-checking bench for cla_pipe (WIDTH=64, STAGES=4, GROUP=4).
// A queue-based reference model predicts every consumed result from plain
// wide arithmetic; directed vectors pin exact values and latency.
module tb_cla_pipe;

  localparam int W = 64;
  localparam int S = 4;

  logic         in_clk = 1'b0;
  logic         in_reset;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         in_carry;
  logic         in_sub;
  logic         out_valid;
  logic         in_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_overflow;
  logic         out_zero;

  always #5 in_clk = ~in_clk;

  cla_pipe #(.WIDTH(W), .STAGES(S), .GROUP(4)) dut (
    .in_clk       (in_clk),
    .in_reset     (in_reset),
    .in_valid     (in_valid),
    .out_ready    (out_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_carry     (in_carry),
    .in_sub       (in_sub),
    .out_valid    (out_valid),
    .in_ready     (in_ready),
    .out_sum      (out_sum),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .out_zero     (out_zero)
  );

  int n_checks   = 0;
  int n_pass     = 0;
  int cyc        = 0;
  int n_consumed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct packed {
    logic [63:0] sum;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  // Reference: true integer arithmetic. Carry is the unsigned carry-out for
  // add and "no borrow" for sub; overflow is the signed result not fitting in 64 bits.
  function automatic res_t model(input logic [63:0] x, input logic [63:0] y,
                                 input logic c, input logic sub);
    res_t        r;
    logic [64:0] u;
    logic [65:0] sv;
    if (!sub) begin
      u     = {1'b0, x} + {1'b0, y} + 65'(c);
      r.sum = u[63:0];
      r.c   = u[64];
      sv    = {{2{x[63]}}, x} + {{2{y[63]}}, y} + 66'(c);
    end else begin
      r.sum = x - y - 64'(c);
      r.c   = ({1'b0, x} >= ({1'b0, y} + 65'(c)));
      sv    = {{2{x[63]}}, x} - {{2{y[63]}}, y} - 66'(c);
    end
    r.v = !((sv[65:63] == 3'b000) || (sv[65:63] == 3'b111));
    r.z = (r.sum == 64'd0);
    return r;
  endfunction

  res_t        exp_q[$];
  res_t        e;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_sum;
  logic [3:0]  prev_flags;

  // Compare process: predicts on accept, checks on consume, checks holds on stall.
  always @(negedge in_clk) begin
    cyc++;
    if (prev_stall) begin
      check("stall_hold_sum", out_sum, prev_sum);
      check("stall_hold_flags", 64'({out_valid, out_carry, out_overflow, out_zero}),
            64'(prev_flags));
    end
    if (in_reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (out_valid && !in_ready) check("stall_out_ready", 64'(out_ready), 64'd0);
      if (out_valid && in_ready) begin
        n_consumed++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("model_sum", out_sum, e.sum);
          check("model_carry", 64'(out_carry), 64'(e.c));
          check("model_ovf", 64'(out_overflow), 64'(e.v));
          check("model_zero", 64'(out_zero), 64'(e.z));
        end
      end
      if (in_valid && out_ready) exp_q.push_back(model(in_x, in_y, in_carry, in_sub));
      prev_stall = out_valid && !in_ready;
      prev_sum   = out_sum;
      prev_flags = {out_valid, out_carry, out_overflow, out_zero};
    end
  end

  // Present a beat and return #1 after the edge that accepted it (in_valid left high).
  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic c, input logic s);
    int t;
    in_x     = x;
    in_y     = y;
    in_carry = c;
    in_sub   = s;
    in_valid = 1'b1;
    for (t = 0; t < 50; t++) begin
      @(negedge in_clk);
      if (out_ready) break;
    end
    if (t == 50) check("accept_timeout", 64'(out_ready), 64'd1);
    @(posedge in_clk);
    #1;
  endtask

  // Single beat into an idle pipe with literal expected results and latency.
  task automatic directed(input string nm, input logic [63:0] x, input logic [63:0] y,
                          input logic c, input logic s, input logic [63:0] es,
                          input logic ec, input logic ev, input logic ez);
    int lat;
    send(x, y, c, s);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge in_clk);
      #1;
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'(S));
    check({nm, "_sum"}, out_sum, es);
    check({nm, "_carry"}, 64'(out_carry), 64'(ec));
    check({nm, "_ovf"}, 64'(out_overflow), 64'(ev));
    check({nm, "_zero"}, 64'(out_zero), 64'(ez));
    @(posedge in_clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      @(negedge in_clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge in_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    int n0;
    int ghost;
    in_reset = 1'b1;
    in_valid = 1'b0;
    in_ready = 1'b1;
    in_x     = '0;
    in_y     = '0;
    in_carry = 1'b0;
    in_sub   = 1'b0;
    repeat (2) @(posedge in_clk);
    #1;
    in_reset = 1'b0;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_ready", 64'(out_ready), 64'd1);

    // Directed vectors
    directed("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
             64'd0, 1'b1, 1'b0, 1'b1);
    directed("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    directed("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b0);
    directed("sub_equal", 64'h1234, 64'h1234, 1'b0, 1'b1,
             64'd0, 1'b1, 1'b0, 1'b1);
    directed("sub_zero_bin", 64'd0, 64'd0, 1'b1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream: one accept per cycle
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      send({$urandom, $urandom}, {$urandom, $urandom},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    check("stream_cycles", 64'(cyc - c0), 64'd100);
    drain();

    // Backpressure: in_ready low for 3 cycles while results are waiting
    n0 = n_consumed;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(64'h0123_4567_89AB_CDEF * 64'(i + 1), 64'hFEDC_BA98_7654_3210 + 64'(i),
               1'(i), 1'(i >> 1));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge in_clk);
        #1;
        in_ready = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
        in_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 64'(n_consumed - n0), 64'd6);

    // Reset mid-flight: three beats in the pipe are discarded
    send(64'd10, 64'd20, 1'b0, 1'b0);
    send(64'd30, 64'd40, 1'b0, 1'b0);
    send(64'd50, 64'd60, 1'b1, 1'b1);
    in_valid = 1'b0;
    in_reset = 1'b1;
    @(posedge in_clk);
    #1;
    in_reset = 1'b0;
    check("reset_flush_valid", 64'(out_valid), 64'd0);
    ghost = 0;
    repeat (8) begin
      @(negedge in_clk);
      if (out_valid) ghost++;
    end
    check("reset_no_ghost", 64'(ghost), 64'd0);
    @(posedge in_clk);
    #1;
    directed("post_reset", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
